// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg -- shared types for the shift_arb arbiter/delay-line block.
//   state_e     : controller states (RUN, DRAIN)
//   stage_t     : pipeline stage layout {valid, id, data}, sized for the
//                 default configuration (4 requesters, 8-bit beats).
//                 shift_arb builds the same layout from its own parameters.
//   stage_width : packed width of a stage for a given configuration.
package shift_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ID_W       = $clog2(DEF_NUM_REQ);

  typedef struct packed {
    logic                      valid;
    logic [DEF_ID_W-1:0]       id;
    logic [DEF_DATA_WIDTH-1:0] data;
  } stage_t;

  function automatic int stage_width(input int num_req, input int data_width);
    return 1 + $clog2(num_req) + data_width;
  endfunction

endpackage

// File: rtl/shift_arb_rr_pick.sv
// rr_pick -- combinational round-robin picker.
// Ports:
//   req   : request vector
//   last  : index of the previous winner; search starts at last+1 and wraps
//   grant : one-hot winner (all 0 when no request)
//   idx   : encoded winner index (0 when no request)
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic found;

  // First pass takes the lowest request above last; the second pass wraps
  // around to the lowest request overall.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (j > int'(last))) begin
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        found    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_reg.sv
// shift_reg -- fixed-depth delay line, every stage advances every cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears every stage to 0
//   d    : word entering stage 0
//   q    : word leaving the last stage (NUM_REGS cycles after entry)
module shift_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      regs[0] <= d;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= regs[i-1];
    end
  end

  assign q = regs[NUM_REGS-1];

endmodule

// File: rtl/shift_arb.sv
// shift_arb -- round-robin arbiter feeding a fixed-latency delay line, with
// a drain handshake that stops accepting until the pipeline is empty.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | accepting one beat per cycle, round-robin
//   DRAIN | no grants; waits for occupancy 0, then pulses drain_done
//
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   req_valid  : per-requester beat offered
//   req_data   : requester i owns [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : one-hot grant, only for a requester with valid
//   drain      : one-cycle pulse requesting a pipeline drain
//   lock       : (SHIFT_ARB_LOCK_EN only) requester keeps grant while locked
//   rsp_valid  : one-hot owner of the beat leaving the pipeline
//   rsp_data   : beat leaving the pipeline; holds last value on bubbles
//   drain_done : one-cycle pulse when a drain completes
//   busy       : occupancy nonzero or draining
//
// Optional feature macro: SHIFT_ARB_LOCK_EN (adds the lock input).
module shift_arb
  import shift_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int NUM_REGS   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          drain,
`ifdef SHIFT_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock,
`endif
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          drain_done,
  output logic                          busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int OCC_W = $clog2(NUM_REGS + 1);
  localparam int ST_W  = stage_width(NUM_REQ, DATA_WIDTH);

  typedef struct packed {
    logic                  valid;
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } pipe_t;

  state_e                state;
  logic [OCC_W-1:0]      occ;
  logic [ID_W-1:0]       last_grant;
  logic [DATA_WIDTH-1:0] rsp_hold;
  logic                  rst_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [ID_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]    sel_grant;
  logic [ID_W-1:0]       sel_idx;
  logic                  grant_en;
  logic                  accept;
  logic                  emit;
  pipe_t                 pipe_in;
  pipe_t                 pipe_out;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

`ifdef SHIFT_ARB_LOCK_EN
  logic lock_hold;
  assign lock_hold = req_valid[last_grant] & lock[last_grant];
  assign sel_grant = lock_hold ? (NUM_REQ'(1) << last_grant) : pick_grant;
  assign sel_idx   = lock_hold ? last_grant : pick_idx;
`else
  assign sel_grant = pick_grant;
  assign sel_idx   = pick_idx;
`endif

  // Grants are withheld during reset and the cycle after it, and in DRAIN
  // (which also makes drain override lock).
  assign grant_en  = (state == RUN) && !rst && !rst_d;
  assign req_ready = grant_en ? sel_grant : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    pipe_in = '0;
    if (accept) begin
      pipe_in.valid = 1'b1;
      pipe_in.id    = sel_idx;
      pipe_in.data  = req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  shift_reg #(.DATA_WIDTH(ST_W), .NUM_REGS(NUM_REGS)) u_pipe (
    .clk (clk),
    .rst (rst),
    .d   (pipe_in),
    .q   (pipe_out)
  );

  assign emit = pipe_out.valid;

  always_ff @(posedge clk) begin
    rst_d <= rst;
    if (rst) begin
      state      <= RUN;
      occ        <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_hold   <= '0;
    end else begin
      case (state)
        RUN:     if (drain) state <= DRAIN;
        DRAIN:   if (occ == '0) state <= RUN;
        default: state <= RUN;
      endcase
      if (accept) last_grant <= sel_idx;
      case ({accept, emit})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (emit) rsp_hold <= pipe_out.data;
    end
  end

  assign rsp_valid  = (emit && !rst) ? (NUM_REQ'(1) << pipe_out.id) : '0;
  assign rsp_data   = rst ? '0 : (emit ? pipe_out.data : rsp_hold);
  assign busy       = !rst && ((occ != '0) || (state == DRAIN));
  assign drain_done = !rst && (state == DRAIN) && (occ == '0);

`ifndef SYNTHESIS
  occ_overflow: assert property (@(posedge clk) disable iff (rst)
    !(accept && !emit && (occ == OCC_W'(NUM_REGS))));
  occ_underflow: assert property (@(posedge clk) disable iff (rst)
    !(emit && !accept && (occ == '0)));
  occ_bound: assert property (@(posedge clk) disable iff (rst)
    occ <= OCC_W'(NUM_REGS));
`endif

endmodule

// File: tb/tb_shift_arb.sv
module tb_shift_arb;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int NRG = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            drain = 1'b0;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            drain_done;
  logic            busy;
`ifdef SHIFT_ARB_LOCK_EN
  logic [NR-1:0]   lock = '0;
  logic [NR-1:0]   lock_nxt = '0;
`endif

  shift_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .NUM_REGS(NRG)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .drain      (drain),
`ifdef SHIFT_ARB_LOCK_EN
    .lock       (lock),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .drain_done (drain_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[$];   // responses the monitor must see, in order
  int            pend[$];    // model's own in-flight list (emit cycles)
  int            last_g;
  bit            drain_mode;
  bit            post_rst;
  bit            mon_en = 1'b0;
  logic [DW-1:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_model(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (last + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: pops one expected response whenever the DUT emits one.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
          last_data = e.data;
        end
      end else begin
        chk("rsp_hold", 32'(rsp_data), 32'(last_data));
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          chk("rsp_missing", 32'(rsp_valid), 32'(1 << e.id));
        end
      end
    end
  end

  task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic dr);
    int            occ;
    int            g;
    logic [NR-1:0] exp_ready;
    @(negedge clk);
    #1;
    rst       = 1'b0;
    req_valid = v;
    req_data  = d;
    drain     = dr;
`ifdef SHIFT_ARB_LOCK_EN
    lock      = lock_nxt;
`endif
    #1;
    while (pend.size() > 0 && pend[0] < cyc) void'(pend.pop_front());
    occ = pend.size();
    g = -1;
    if (!drain_mode && !post_rst) begin
`ifdef SHIFT_ARB_LOCK_EN
      if (v[last_g] && lock_nxt[last_g]) g = last_g;
      else
`endif
      g = rr_model(v, last_g);
    end
    exp_ready = (g >= 0) ? NR'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(occ != 0 || drain_mode));
    chk("drain_done", 32'(drain_done), 32'(drain_mode && occ == 0));
    if (g >= 0) begin
      exp_q.push_back('{g, d[g*DW +: DW], cyc + NRG});
      pend.push_back(cyc + NRG);
      last_g = g;
    end
    if (drain_mode) begin
      if (occ == 0) drain_mode = 1'b0;
    end else if (dr) begin
      drain_mode = 1'b1;
    end
    post_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      rst       = 1'b1;
      req_valid = NR'($urandom);
      drain     = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_drain_done", 32'(drain_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      pend.delete();
      last_g     = NR - 1;
      drain_mode = 1'b0;
      last_data  = '0;
      post_rst   = 1'b1;
    end
    mon_en = 1'b1;
  endtask

  initial begin
    do_reset(2);

    // cycle right after reset: no grant even with all valid
    step('1, $urandom, 1'b0);

    // all valid for 8 cycles: 0,1,2,3,0,1,2,3
    repeat (8) step('1, $urandom, 1'b0);
    idle(NRG + 2);

    // single requester 2 with 0xA5
    step(4'b0100, 32'h00A5_0000, 1'b0);
    idle(NRG + 3);

    // three beats in flight, then drain; requests held during drain,
    // plus a second drain pulse while already draining
    step(4'b0001, $urandom, 1'b0);
    step(4'b0010, $urandom, 1'b0);
    step(4'b1000, $urandom, 1'b0);
    step('0, '0, 1'b1);
    step('1, $urandom, 1'b0);
    step('1, $urandom, 1'b1);
    repeat (NRG + 2) step('1, $urandom, 1'b0);
    idle(NRG + 2);

    // drain with empty pipeline
    step('0, '0, 1'b1);
    idle(3);

    // beat offered in the same cycle as drain is still taken
    step(4'b0010, $urandom, 1'b1);
    idle(NRG + 3);

    // reset with 5 beats in flight: none may emerge afterwards
    repeat (5) step('1, $urandom, 1'b0);
    idle(2);
    do_reset(1);
    step('1, $urandom, 1'b0);
    step('1, $urandom, 1'b0);
    idle(NRG + 4);

`ifdef SHIFT_ARB_LOCK_EN
    do_reset(1);
    idle(1);
    lock_nxt = 4'b0010;
    repeat (4) step(4'b1010, $urandom, 1'b0);
    lock_nxt = '0;
    repeat (2) step(4'b1010, $urandom, 1'b0);
    idle(NRG + 2);
`endif

    // randomized traffic with occasional drain pulses
    for (int i = 0; i < 400; i++) begin
`ifdef SHIFT_ARB_LOCK_EN
      lock_nxt = NR'($urandom);
`endif
      step(NR'($urandom_range(0, 15)), {$urandom}, ($urandom_range(0, 24) == 0));
    end
`ifdef SHIFT_ARB_LOCK_EN
    lock_nxt = '0;
`endif
    idle(NRG + 4);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
